// File: rtl/l2_victim_buffer_if.sv
// Line-granular request/response bus shared by the L2 side and the memory side.
// The master issues address/read/write/wdata; the slave returns rdata and a resp pulse.
interface l2_victim_buffer_if;
    logic [31:0]  address;
    logic         read;
    logic         write;
    logic [255:0] wdata;
    logic [255:0] rdata;
    logic         resp;

    modport master (output address, read, write, wdata, input rdata, resp);
    modport slave  (input address, read, write, wdata, output rdata, resp);
endinterface

// File: rtl/l2_victim_buffer.sv
// Write-back victim buffer: absorbs dirty L2 evictions in a small FIFO, serves read hits
// from it, lets read misses bypass pending drains, and drains to memory when L2 is idle.
module l2_victim_buffer #(
    parameter int depth = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    l2_victim_buffer_if.slave  l2,
    l2_victim_buffer_if.master pmem
);
    localparam int PTR_W = $clog2(depth);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(depth);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] READ_MEM  = 2'd1;
    localparam logic [1:0] WRITE_MEM = 2'd2;
    localparam logic [1:0] RESP      = 2'd3;

    logic [1:0]       state;
    logic [depth-1:0] valid;
    logic [26:0]      tag_mem  [depth];
    logic [255:0]     data_mem [depth];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] hit_idx;
    logic [CNT_W-1:0] count;
    logic [255:0]     rdata_q;
    logic [255:0]     wdata_q;
    logic [31:0]      paddr_q;

    logic hit;
    logic full;
    logic in_idle;
    logic do_read_hit;
    logic do_read_miss;
    logic do_coalesce;
    logic do_push;
    logic do_drain;

    wire unused_addr_bits = &{1'b0, l2.address[4:0]};

    // Coalescing keeps tags unique, so at most one entry can match.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < depth; i++) begin
            if (valid[i] && (tag_mem[i] == l2.address[31:5])) begin
                hit     = 1'b1;
                hit_idx = PTR_W'(i);
            end
        end
    end

    assign full         = (count == FULL_COUNT);
    assign in_idle      = (state == IDLE);
    assign do_read_hit  = in_idle &  l2.read &  hit;
    assign do_read_miss = in_idle &  l2.read & ~hit;
    assign do_coalesce  = in_idle & ~l2.read &  l2.write &  hit;
    assign do_push      = in_idle & ~l2.read &  l2.write & ~hit & ~full;
    assign do_drain     = in_idle & ~l2.read &
                          (l2.write ? (~hit & full) : (count != '0));

    // Line storage needs no reset: valid bits alone decide what is live.
    always_ff @(posedge clk) begin
        if (do_coalesce) begin
            data_mem[hit_idx] <= l2.wdata;
        end else if (do_push) begin
            data_mem[tail] <= l2.wdata;
            tag_mem[tail]  <= l2.address[31:5];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            valid   <= '0;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            rdata_q <= '0;
            wdata_q <= '0;
            paddr_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (do_read_hit) begin
                        rdata_q <= data_mem[hit_idx];
                        state   <= RESP;
                    end else if (do_read_miss) begin
                        paddr_q <= {l2.address[31:5], 5'b0};
                        state   <= READ_MEM;
                    end else if (do_coalesce) begin
                        state   <= RESP;
                    end else if (do_push) begin
                        valid[tail] <= 1'b1;
                        tail        <= tail + 1'b1;
                        count       <= count + 1'b1;
                        state       <= RESP;
                    end else if (do_drain) begin
                        // A full-buffer write stays pending and is retried after this drain.
                        paddr_q <= {tag_mem[head], 5'b0};
                        wdata_q <= data_mem[head];
                        state   <= WRITE_MEM;
                    end
                end
                READ_MEM: begin
                    if (pmem.resp) begin
                        rdata_q <= pmem.rdata;
                        state   <= RESP;
                    end
                end
                WRITE_MEM: begin
                    if (pmem.resp) begin
                        valid[head] <= 1'b0;
                        head        <= head + 1'b1;
                        count       <= count - 1'b1;
                        state       <= IDLE;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign l2.rdata     = rdata_q;
    assign l2.resp      = (state == RESP);
    assign pmem.address = paddr_q;
    assign pmem.read    = (state == READ_MEM);
    assign pmem.write   = (state == WRITE_MEM);
    assign pmem.wdata   = wdata_q;
endmodule
